// File: rtl/text_vram_arbiter_pkg.sv
// Shared definitions for the text VRAM arbiter: clear-sequencer states and
// default widths / blank code.
package text_vram_arbiter_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CLR  = 1'b1
  } clr_state_e;

  localparam int         TVA_AW    = 10;
  localparam int         TVA_DW    = 8;
  localparam logic [7:0] TVA_BLANK = 8'h20;

endpackage

// File: rtl/text_vram_wfifo.sv
// Small synchronous FIFO of {address, data} host writes waiting for a free
// VRAM slot. Caller guarantees no push when full and no pop when empty.
module text_vram_wfifo
  import text_vram_arbiter_pkg::*;
#(
  parameter int C_AW       = TVA_AW,
  parameter int C_DW       = TVA_DW,
  parameter int C_FQ_DEPTH = 4
) (
  input  logic                          ck_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [C_AW-1:0]               push_adr_i,
  input  logic [C_DW-1:0]               push_wd_i,
  input  logic                          pop_i,
  output logic [C_AW-1:0]               head_adr_o,
  output logic [C_DW-1:0]               head_wd_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(C_FQ_DEPTH):0]   cnt_o
);

  localparam int PW = $clog2(C_FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [C_AW-1:0] adr_mem_q [C_FQ_DEPTH];
  logic [C_AW-1:0] adr_mem_d [C_FQ_DEPTH];
  logic [C_DW-1:0] wd_mem_q  [C_FQ_DEPTH];
  logic [C_DW-1:0] wd_mem_d  [C_FQ_DEPTH];
  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    adr_mem_d = adr_mem_q;
    wd_mem_d  = wd_mem_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    if (push_i) begin
      adr_mem_d[wp_q] = push_adr_i;
      wd_mem_d[wp_q]  = push_wd_i;
      wp_d            = wp_q + PW'(1);
    end
    if (pop_i) begin
      rp_d = rp_q + PW'(1);
    end
    // simultaneous push and pop leaves the occupancy unchanged
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge ck_i) begin
    adr_mem_q <= adr_mem_d;
    wd_mem_q  <= wd_mem_d;
  end

  assign head_adr_o = adr_mem_q[rp_q];
  assign head_wd_o  = wd_mem_q[rp_q];
  assign full_o     = (cnt_q == CW'(C_FQ_DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/text_vram_arbiter.sv
// Single-port text VRAM arbiter: video fetch > clear sequencer > host FIFO.
// Holds the clear FSM and the two-stage video read-return pipeline.
//
//   state  | meaning
//   S_IDLE | no clear running; free slots drain the host FIFO
//   S_CLR  | writing blank code to cells 0..C_DEPTH-1, FIFO held
module text_vram_arbiter
  import text_vram_arbiter_pkg::*;
#(
  parameter int              C_AW       = TVA_AW,
  parameter int              C_DW       = TVA_DW,
  parameter int              C_DEPTH    = 1000,
  parameter logic [C_DW-1:0] C_BLANK    = C_DW'(TVA_BLANK),
  parameter int              C_FQ_DEPTH = 4
) (
  input  logic                        CK_i,
  input  logic                        RST_i,
  input  logic                        CK_EE_i,
  input  logic                        VID_REQ_i,
  input  logic [C_AW-1:0]             VID_ADRs_i,
  output logic [C_DW-1:0]             VID_RDs_o,
  output logic                        VID_RDV_o,
  input  logic                        HOST_VALID_i,
  output logic                        HOST_READY_o,
  input  logic [C_AW-1:0]             HOST_ADRs_i,
  input  logic [C_DW-1:0]             HOST_WDs_i,
  input  logic                        CLR_REQ_i,
  output logic                        CLR_BUSY_o,
  output logic [$clog2(C_FQ_DEPTH):0] FQ_CNTs_o,
  output logic [C_AW-1:0]             RAM_ADRs_o,
  output logic                        RAM_WE_o,
  output logic [C_DW-1:0]             RAM_WDs_o,
  input  logic [C_DW-1:0]             RAM_RDs_i
);

  clr_state_e      state_q, state_d;
  logic [C_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [C_AW-1:0] adr_q, adr_d;
  logic            rv1_q, rv1_d;
  logic            rdv_q, rdv_d;
  logic [C_DW-1:0] rd_q, rd_d;

  logic            en, gnt_vid, gnt_clr, gnt_fq;
  logic            fq_full, fq_empty, fq_push;
  logic [C_AW-1:0] fq_adr;
  logic [C_DW-1:0] fq_wd;

  // no slot is granted while reset is asserted, so nothing is written then
  assign en = CK_EE_i & ~RST_i;

  always_comb begin
    gnt_vid    = en & VID_REQ_i;
    gnt_clr    = en & ~VID_REQ_i & (state_q == S_CLR);
    gnt_fq     = en & ~VID_REQ_i & (state_q == S_IDLE) & ~fq_empty;
    RAM_ADRs_o = adr_q;
    RAM_WE_o   = 1'b0;
    RAM_WDs_o  = '0;
    if (gnt_vid) begin
      RAM_ADRs_o = VID_ADRs_i;
    end else if (gnt_clr) begin
      RAM_ADRs_o = clr_cnt_q;
      RAM_WE_o   = 1'b1;
      RAM_WDs_o  = C_BLANK;
    end else if (gnt_fq) begin
      RAM_ADRs_o = fq_adr;
      RAM_WE_o   = 1'b1;
      RAM_WDs_o  = fq_wd;
    end
    adr_d = RAM_ADRs_o;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rv1_d     = rv1_q;
    rdv_d     = rdv_q;
    rd_d      = rd_q;
    if (CK_EE_i) begin
      rv1_d = VID_REQ_i;
      rdv_d = rv1_q;
      if (rv1_q) rd_d = RAM_RDs_i;
      case (state_q)
        S_IDLE: begin
          if (CLR_REQ_i) begin
            state_d   = S_CLR;
            clr_cnt_d = '0;
          end
        end
        S_CLR: begin
          if (gnt_clr) begin
            if (clr_cnt_q == C_AW'(C_DEPTH - 1)) state_d = S_IDLE;
            else clr_cnt_d = clr_cnt_q + C_AW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= '0;
      adr_q     <= '0;
      rv1_q     <= 1'b0;
      rdv_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      adr_q     <= adr_d;
      rv1_q     <= rv1_d;
      rdv_q     <= rdv_d;
      rd_q      <= rd_d;
    end
  end

  assign VID_RDV_o    = rdv_q;
  assign VID_RDs_o    = rd_q;
  assign CLR_BUSY_o   = (state_q == S_CLR);
  assign HOST_READY_o = ~fq_full;
  assign fq_push      = HOST_VALID_i & ~fq_full & en;

  text_vram_wfifo #(
    .C_AW       (C_AW),
    .C_DW       (C_DW),
    .C_FQ_DEPTH (C_FQ_DEPTH)
  ) u_wfifo (
    .ck_i       (CK_i),
    .rst_i      (RST_i),
    .push_i     (fq_push),
    .push_adr_i (HOST_ADRs_i),
    .push_wd_i  (HOST_WDs_i),
    .pop_i      (gnt_fq),
    .head_adr_o (fq_adr),
    .head_wd_o  (fq_wd),
    .full_o     (fq_full),
    .empty_o    (fq_empty),
    .cnt_o      (FQ_CNTs_o)
  );

endmodule

// File: tb/tb_text_vram_arbiter.sv
// Bench for text_vram_arbiter: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_text_vram_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1000;
  localparam int FQD   = 4;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic v; logic [DW-1:0] d; } rd_t;

  logic          clk, rst, ck_ee, vid_req, host_valid, clr_req;
  logic [AW-1:0] vid_adr, host_adr;
  logic [DW-1:0] host_wd, ram_rd;
  logic [DW-1:0] vid_rd, ram_wd;
  logic          vid_rdv, host_ready, clr_busy, ram_we;
  logic [2:0]    fq_cnt;
  logic [AW-1:0] ram_adr;

  text_vram_arbiter dut (
    .CK_i         (clk),
    .RST_i        (rst),
    .CK_EE_i      (ck_ee),
    .VID_REQ_i    (vid_req),
    .VID_ADRs_i   (vid_adr),
    .VID_RDs_o    (vid_rd),
    .VID_RDV_o    (vid_rdv),
    .HOST_VALID_i (host_valid),
    .HOST_READY_o (host_ready),
    .HOST_ADRs_i  (host_adr),
    .HOST_WDs_i   (host_wd),
    .CLR_REQ_i    (clr_req),
    .CLR_BUSY_o   (clr_busy),
    .FQ_CNTs_o    (fq_cnt),
    .RAM_ADRs_o   (ram_adr),
    .RAM_WE_o     (ram_we),
    .RAM_WDs_o    (ram_wd),
    .RAM_RDs_i    (ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // VRAM seen by the DUT, and the model's view of what it should contain
  logic [DW-1:0] vram    [1024];
  logic [DW-1:0] ref_mem [1024];

  // reference model state
  wr_t           fq[$];
  rd_t           hist[$];
  bit            clr_on;
  int            clr_idx;
  logic [AW-1:0] exp_adr;
  logic          exp_rdv;
  logic [DW-1:0] exp_rd;

  int            busy_cnt;
  logic [DW-1:0] rd_log[$];
  bit            post_rst_chk;

  // source: 0 none, 1 video, 2 clear, 3 host FIFO
  task automatic model_grant(output int src, output logic [AW-1:0] ga, output logic [DW-1:0] gw);
    src = 0; ga = exp_adr; gw = '0;
    if (ck_ee && !rst) begin
      if (vid_req) begin
        src = 1; ga = vid_adr;
      end else if (clr_on) begin
        src = 2; ga = AW'(clr_idx); gw = 8'h20;
      end else if (fq.size() > 0) begin
        src = 3; ga = fq[0].a; gw = fq[0].d;
      end
    end
  endtask

  task automatic model_reset();
    fq.delete();
    hist.delete();
    hist.push_back('0);
    clr_on  = 0;
    clr_idx = 0;
    exp_adr = '0;
    exp_rdv = 1'b0;
    exp_rd  = '0;
  endtask

  task automatic model_edge();
    int src, pre;
    bit clr_pre;
    logic [AW-1:0] ga;
    logic [DW-1:0] gw;
    rd_t r, o;
    wr_t w;
    if (rst) begin
      model_reset();
      return;
    end
    if (!ck_ee) return;
    model_grant(src, ga, gw);
    pre = fq.size();
    clr_pre = clr_on;
    if (src != 0) exp_adr = ga;
    r.v = (src == 1);
    r.d = (src == 1) ? ref_mem[ga] : '0;
    hist.push_back(r);
    if (src >= 2) ref_mem[ga] = gw;
    if (src == 2) begin
      clr_idx++;
      if (clr_idx == DEPTH) clr_on = 0;
    end
    if (src == 3) w = fq.pop_front();
    o = hist.pop_front();
    exp_rdv = o.v;
    if (o.v) exp_rd = o.d;
    if (host_valid && pre < FQD) begin
      w.a = host_adr; w.d = host_wd;
      fq.push_back(w);
    end
    if (!clr_pre && clr_req) begin
      clr_on = 1; clr_idx = 0;
    end
  endtask

  task automatic check_cycle();
    int src;
    logic [AW-1:0] ga;
    logic [DW-1:0] gw;
    model_grant(src, ga, gw);
    check_eq("ram_we", 32'(ram_we), 32'(src >= 2));
    check_eq("ram_adr", 32'(ram_adr), 32'(ga));
    if (src >= 2) check_eq("ram_wd", 32'(ram_wd), 32'(gw));
    check_eq("host_ready", 32'(host_ready), 32'(fq.size() < FQD));
    check_eq("fq_cnt", 32'(fq_cnt), 32'(fq.size()));
    check_eq("clr_busy", 32'(clr_busy), 32'(clr_on));
    check_eq("vid_rdv", 32'(vid_rdv), 32'(exp_rdv));
    check_eq("vid_rd", 32'(vid_rd), 32'(exp_rd));
  endtask

  task automatic step();
    logic s_we, s_en;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wd;
    @(negedge clk);
    if (!rst) check_cycle();
    if (post_rst_chk) begin
      check_eq("rst_clr_busy", 32'(clr_busy), 32'd0);
      check_eq("rst_fq_cnt", 32'(fq_cnt), 32'd0);
      check_eq("rst_ram_we", 32'(ram_we), 32'd0);
      post_rst_chk = 0;
    end
    if (clr_busy) busy_cnt++;
    if (vid_rdv) rd_log.push_back(vid_rd);
    s_we = ram_we; s_adr = ram_adr; s_wd = ram_wd; s_en = ck_ee;
    @(posedge clk);
    model_edge();
    #1;
    if (s_en) begin
      ram_rd = vram[s_adr];
      if (s_we) vram[s_adr] = s_wd;
    end
  endtask

  task automatic load_mem();
    logic [DW-1:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = 8'h80 | DW'($urandom_range(0, 127));
      vram[i] = v;
      ref_mem[i] = v;
    end
  endtask

  task automatic idle(input int n);
    vid_req = 0; host_valid = 0; clr_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    rst = 1; ck_ee = 1; vid_req = 0; vid_adr = '0; host_valid = 0;
    host_adr = '0; host_wd = '0; clr_req = 0; ram_rd = '0;
    post_rst_chk = 0; busy_cnt = 0;
    model_reset();
    load_mem();
    vram[5] = 8'h41; ref_mem[5] = 8'h41;
    vram[6] = 8'h42; ref_mem[6] = 8'h42;
    vram[7] = 8'h43; ref_mem[7] = 8'h43;
    step(); step();
    rst = 0;
    post_rst_chk = 1;

    // video reads 5,6,7 back to back
    rd_log.delete();
    for (int i = 5; i <= 7; i++) begin
      vid_req = 1; vid_adr = AW'(i); step();
    end
    idle(4);
    check_eq("vid_rd_count", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() == 3) begin
      check_eq("vid_rd0", 32'(rd_log[0]), 32'h41);
      check_eq("vid_rd1", 32'(rd_log[1]), 32'h42);
      check_eq("vid_rd2", 32'(rd_log[2]), 32'h43);
    end

    // single host write, then read it back
    host_valid = 1; host_adr = 10'd3; host_wd = 8'h55; step();
    idle(3);
    rd_log.delete();
    vid_req = 1; vid_adr = 10'd3; step();
    idle(3);
    check_eq("host_rd_back_n", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() == 1) check_eq("host_rd_back", 32'(rd_log[0]), 32'h55);

    // FIFO fills behind continuous video
    for (int i = 0; i < 5; i++) begin
      vid_req = 1; vid_adr = AW'($urandom);
      host_valid = 1; host_adr = AW'(100 + i); host_wd = DW'(8'hA0 + i);
      step();
    end
    host_valid = 0;
    check_eq("fq_full_cnt", 32'(fq_cnt), 32'd4);
    check_eq("fq_full_ready", 32'(host_ready), 32'd0);
    idle(6);
    check_eq("drain_last", 32'(vram[103]), 32'hA3);

    // full clear with a host write and a second request in the middle
    busy_cnt = 0;
    clr_req = 1; step(); clr_req = 0;
    for (int i = 0; i < 1010; i++) begin
      host_valid = (i == 100); host_adr = 10'd10; host_wd = 8'h7F;
      clr_req = (i == 300);
      step();
    end
    idle(3);
    check_eq("clr_busy_len", 32'(busy_cnt), 32'd1000);
    check_eq("clr_host_10", 32'(vram[10]), 32'h7F);
    check_eq("clr_blank_11", 32'(vram[11]), 32'h20);
    check_eq("clr_blank_999", 32'(vram[999]), 32'h20);

    // reset in the middle of a clear
    load_mem();
    clr_req = 1; step(); clr_req = 0;
    for (int i = 0; i < 500; i++) begin
      host_valid = (i == 50); host_adr = 10'd900; host_wd = 8'h11;
      step();
    end
    host_valid = 0;
    rst = 1; step(); rst = 0;
    post_rst_chk = 1;
    idle(3);
    n = 0;
    for (int i = 500; i < DEPTH; i++) if (vram[i] == 8'h20) n++;
    check_eq("clr_abort_hi", 32'(n), 32'd0);
    check_eq("clr_abort_lo", 32'(vram[499]), 32'h20);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      ck_ee      = ($urandom_range(0, 9) != 0);
      vid_req    = ($urandom_range(0, 2) == 0);
      vid_adr    = AW'($urandom);
      host_valid = $urandom_range(0, 1) == 1;
      host_adr   = AW'($urandom);
      host_wd    = DW'($urandom);
      clr_req    = ($urandom_range(0, 799) == 0);
      rst        = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 0; ck_ee = 1;
    idle(5);

    n = 0;
    for (int i = 0; i < 1024; i++) if (vram[i] !== ref_mem[i]) n++;
    check_eq("vram_contents", 32'(n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/text_vram_arbiter.md
Name: text_vram_arbiter

Overview:
- Shares one single-port text VRAM (character codes for the 5x7 font overlay) between three users: the video scan-out fetch, a host write port, and an internal clear-screen sequencer.
- Sits between the video timing/pattern pipeline and the VRAM macro.
- Video fetch is hard-real-time and is never stalled.
- Host writes are buffered in a small FIFO and drained in idle slots. A clear request fills the whole screen with a blank code in background slots.

Parameters:
- C_AW, 10, VRAM address width.
- C_DW, 8, character code width.
- C_DEPTH, 1000, number of cells cleared (40x25 screen); must be <= 2**C_AW.
- C_BLANK, 8'h20, code written by the clear sequencer.
- C_FQ_DEPTH, 4, host write FIFO depth; power of 2, >= 2.

Ports:
- CK_i, in, 1, system clock, 12.27272 MHz.
- RST_i, in, 1, reset; synchronous, active-high.
- CK_EE_i, in, 1, clock enable; all state advances only when 1.
- VID_REQ_i, in, 1, video fetch request, one enabled cycle per cell.
- VID_ADRs_i, in, C_AW, video fetch address.
- VID_RDs_o, out, C_DW, fetched character code.
- VID_RDV_o, out, 1, VID_RDs_o valid strobe.
- HOST_VALID_i, in, 1, host write valid.
- HOST_READY_o, out, 1, host write accepted when VALID&READY&CK_EE_i.
- HOST_ADRs_i, in, C_AW, host write address.
- HOST_WDs_i, in, C_DW, host write data.
- CLR_REQ_i, in, 1, start clear-screen (pulse).
- CLR_BUSY_o, out, 1, clear in progress.
- FQ_CNTs_o, out, clog2(C_FQ_DEPTH)+1, FIFO occupancy.
- RAM_ADRs_o, out, C_AW, VRAM address.
- RAM_WE_o, out, 1, VRAM write enable.
- RAM_WDs_o, out, C_DW, VRAM write data.
- RAM_RDs_i, in, C_DW, VRAM read data; valid one enabled cycle after address.

Behaviour:
- Clocking and reset:
  - Single clock CK_i. Reset RST_i is synchronous and active-high, and is sampled regardless of CK_EE_i.
  - On reset: VID_RDV_o=0, VID_RDs_o=0, HOST_READY_o=1, CLR_BUSY_o=0, FQ_CNTs_o=0, RAM_WE_o=0, RAM_ADRs_o=0, RAM_WDs_o=0.
  - Reset mid-clear aborts the clear. FIFO contents are discarded.
- RAM port signals are combinational from the grant decision. The grant uses fixed priority per enabled cycle: video > clear > FIFO drain.
- Video grant:
  - RAM_ADRs_o=VID_ADRs_i, RAM_WE_o=0.
  - VID_RDs_o is registered from RAM_RDs_i. VID_RDV_o=1 exactly 2 enabled cycles after VID_REQ_i sampled.
  - Latency is fixed; no video request is ever dropped or delayed.
- Clear state machine:
  - States S_IDLE and S_CLR.
  - S_IDLE -> S_CLR on CLR_REQ_i. The clear counter loads 0 and CLR_BUSY_o goes 1 the next cycle.
  - In S_CLR, each slot not taken by video writes C_BLANK at the counter address, then increments the counter.
  - After writing address C_DEPTH-1: -> S_IDLE, CLR_BUSY_o=0.
  - CLR_REQ_i while in S_CLR is ignored (no restart).
- Host FIFO:
  - Push on VALID&READY. HOST_READY_o=~full, computed from registered count. No push when full, even if a pop occurs in the same cycle.
  - Pop when the slot is granted to FIFO: RAM_WE_o=1 with the head entry's address and data.
  - The FIFO does not drain during S_CLR, so host writes issued during a clear land after the clear and take precedence over blanks.
  - Push and pop in the same cycle leave the count unchanged.
- Idle slot: no grant means RAM_WE_o=0 and RAM_ADRs_o holds its last value.
- CK_EE_i=0 freezes all state, including the VID_RDV_o pipeline, and forces RAM_WE_o=0.

Decomposition:
- Shared package/include holds:
  - state encodings S_IDLE and S_CLR;
  - default width constants C_AW and C_DW;
  - the blank code C_BLANK.
- One sub-module is natural: text_vram_wfifo, a synchronous FIFO of {addr, data} with push, pop, full, empty and count outputs.
- The arbiter, clear FSM and read-return pipeline stay in the top.

Test Plan:
- Reset, then video requests at addresses 5, 6, 7 on consecutive cycles, with a RAM model preloaded 5->8'h41, 6->8'h42, 7->8'h43 -> VID_RDV_o high for 3 cycles starting 2 cycles after the first request; data 41, 42, 43.
- Host writes 8'h55 to addr 3 with no video traffic -> RAM_WE_o pulses once at addr 3. A following video read of 3 returns 55.
- VID_REQ_i held high continuously while host pushes 5 writes -> 4 accepted, HOST_READY_o=0, FQ_CNTs_o=4, no RAM_WE_o. Release video -> 4 writes drained in order on 4 consecutive cycles.
- CLR_REQ_i pulse with video idle -> CLR_BUSY_o high for 1000 cycles; every address 0..999 written with 8'h20. A second CLR_REQ_i mid-clear does not extend it.
- Host write (addr 10, 8'h7F) during a clear -> after CLR_BUSY_o falls, addr 10 reads 7F and addr 11 reads 20.
- RST_i asserted at clear count 500 -> next cycle CLR_BUSY_o=0, FQ_CNTs_o=0, RAM_WE_o=0. Addresses >= 500 remain unwritten.
